// File: rtl/capture_readout_if.sv
// BRAM read port plus outgoing byte stream of the capture readout engine.
// The engine takes the master side; the BRAM and the host sink take the slave side.
`timescale 1ns/1ps
interface capture_readout_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 8
);
  logic              bram_en;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_rdata;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_last;
  logic              m_ready;

  modport master (
    output bram_en, bram_addr, m_data, m_valid, m_last,
    input  bram_rdata, m_ready
  );

  modport slave (
    input  bram_en, bram_addr, m_data, m_valid, m_last,
    output bram_rdata, m_ready
  );
endinterface

// File: rtl/capture_readout.sv
// Drains a finished capture from sample BRAM as a valid/ready byte stream.
// A small FIFO plus read credits hide the BRAM latency under any backpressure.
`timescale 1ns/1ps
module capture_readout #(
  parameter int ADDR_W     = 18,
  parameter int DATA_W     = 8,
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [31:0]       control,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] length,
  output logic [31:0]       status,
  capture_readout_if.master bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int CMT_W = CNT_W + 2;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t            state, next_state;
  logic [ADDR_W-1:0] rd_addr, issue_cnt, send_cnt, sent_cnt;
  logic              done_q, zero_pend;
  logic [RD_LAT-1:0] lat_pipe;
  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  fifo_wr, fifo_rd;
  logic [CNT_W-1:0]  fifo_cnt;
  logic [CMT_W-1:0]  committed;

  logic abort, start_ok, issue_first, issue, credit_ok, pop, push, finish, busy;
  logic unused_ctrl;

  assign abort       = control[1];
  assign start_ok    = (state == IDLE) && !zero_pend && control[0] && !abort;
  assign issue_first = start_ok && (length != '0);
  assign pop         = bus.m_valid && bus.m_ready;
  assign push        = lat_pipe[RD_LAT-1];
  assign busy        = (state != IDLE) || zero_pend;
  assign unused_ctrl = ^control[31:2];

  always_ff @(posedge clk or negedge resetn) begin
    // NOTE: every clocked register uses <= so all flops update from pre-edge values.
    if (!resetn) state <= IDLE;
    else         state <= next_state;
  end

  always_comb begin
    // NOTE: defaults first so no path leaves a signal unassigned and infers a latch.
    next_state = state;
    // Reads already promised (buffered, in flight, issuing now) minus the byte
    // leaving this cycle; one more issue must still fit in the FIFO on arrival.
    committed = {2'b00, fifo_cnt} + CMT_W'(bus.bram_en) - CMT_W'(pop);
    for (int i = 0; i < RD_LAT; i++) committed = committed + CMT_W'(lat_pipe[i]);
    credit_ok = committed < CMT_W'(FIFO_DEPTH);
    issue     = (state == RUN) && (issue_cnt != '0) && credit_ok && !abort;
    finish    = pop && (send_cnt == ADDR_W'(1));
    if (abort) begin
      next_state = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (issue_first) next_state = RUN;
        RUN:     if (finish) next_state = IDLE;
                 else if (issue_cnt == '0) next_state = DRAIN;
        DRAIN:   if (finish) next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus.bram_en   <= 1'b0;
      bus.bram_addr <= '0;
      rd_addr       <= '0;
      issue_cnt     <= '0;
      send_cnt      <= '0;
      sent_cnt      <= '0;
      done_q        <= 1'b0;
      zero_pend     <= 1'b0;
    end else begin
      bus.bram_en <= issue_first || issue;
      if (issue_first) begin
        bus.bram_addr <= base_addr;
        rd_addr       <= base_addr + 1'b1;
        issue_cnt     <= length - 1'b1;
      end else if (issue) begin
        bus.bram_addr <= rd_addr;
        rd_addr       <= rd_addr + 1'b1;
        issue_cnt     <= issue_cnt - 1'b1;
      end

      if (start_ok) begin
        send_cnt  <= length;
        sent_cnt  <= '0;
        done_q    <= 1'b0;
        zero_pend <= (length == '0);
      end else begin
        if (pop) begin
          send_cnt <= send_cnt - 1'b1;
          sent_cnt <= sent_cnt + 1'b1;
        end
        if (abort) begin
          zero_pend <= 1'b0;
        end else if (zero_pend) begin
          zero_pend <= 1'b0;
          done_q    <= 1'b1;
        end else if (finish) begin
          done_q <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fifo_wr  <= '0;
      fifo_rd  <= '0;
      fifo_cnt <= '0;
      lat_pipe <= '0;
      // NOTE: the buffer is only a few entries, so it is reset to keep m_data at 0 out of reset.
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
    end else if (abort) begin
      // Flushing the latency pipe discards any read still on its way back.
      fifo_wr  <= '0;
      fifo_rd  <= '0;
      fifo_cnt <= '0;
      lat_pipe <= '0;
    end else begin
      lat_pipe[0] <= bus.bram_en;
      for (int i = 1; i < RD_LAT; i++) lat_pipe[i] <= lat_pipe[i-1];
      if (push) begin
        fifo_mem[fifo_wr] <= bus.bram_rdata;
        fifo_wr           <= fifo_wr + 1'b1;
      end
      if (pop) fifo_rd <= fifo_rd + 1'b1;
      fifo_cnt <= fifo_cnt + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign bus.m_valid = (fifo_cnt != '0);
  assign bus.m_data  = fifo_mem[fifo_rd];
  assign bus.m_last  = bus.m_valid && (send_cnt == ADDR_W'(1));
  assign status      = 32'({sent_cnt, done_q, busy});
endmodule

// File: tb/tb_capture_readout.sv
// Directed bench for capture_readout: one RD_LAT=1 and one RD_LAT=2 instance,
// each fed by a behavioural BRAM with known contents.
`timescale 1ns/1ps
module tb_capture_readout;
  localparam int ADDR_W = 18;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic [31:0]       control, control2;
  logic [ADDR_W-1:0] base_addr, length;
  logic [31:0]       status, status2;

  always #5 clk = ~clk;

  capture_readout_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus1 ();
  capture_readout_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus2 ();

  capture_readout #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(1), .FIFO_DEPTH(4)) dut (
    .clk(clk), .resetn(resetn), .control(control), .base_addr(base_addr),
    .length(length), .status(status), .bus(bus1)
  );

  capture_readout #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(2), .FIFO_DEPTH(4)) dut2 (
    .clk(clk), .resetn(resetn), .control(control2), .base_addr(base_addr),
    .length(length), .status(status2), .bus(bus2)
  );

  // Sample memory: four marker bytes at 0x10, elsewhere low address byte ^ 0x5A.
  function automatic logic [7:0] bram_val(input logic [ADDR_W-1:0] a);
    case (a)
      18'h00010: return 8'hA1;
      18'h00011: return 8'hB2;
      18'h00012: return 8'hC3;
      18'h00013: return 8'hD4;
      default:   return a[7:0] ^ 8'h5A;
    endcase
  endfunction

  logic [7:0] b2_q;
  always @(posedge clk) begin
    if (bus1.bram_en) bus1.bram_rdata <= bram_val(bus1.bram_addr);
    if (bus2.bram_en) b2_q <= bram_val(bus2.bram_addr);
    bus2.bram_rdata <= b2_q;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Logs are taken 1 ns after the falling edge, once the bench has driven its inputs.
  logic [8:0]        rx1 [$];
  logic [8:0]        rx2 [$];
  int                rxc1 [$];
  int                rxc2 [$];
  logic [ADDR_W-1:0] ena1 [$];
  int                enc1 [$];
  int                valid_cnt1 = 0, issued1 = 0, accepted1 = 0, max_out1 = 0;

  always begin
    @(negedge clk);
    #1;
    if (resetn) begin
      if (bus1.bram_en) begin
        ena1.push_back(bus1.bram_addr);
        enc1.push_back(cyc);
        issued1++;
      end
      if (bus1.m_valid) valid_cnt1++;
      if (issued1 - accepted1 > max_out1) max_out1 = issued1 - accepted1;
      if (bus1.m_valid && bus1.m_ready) begin
        rx1.push_back({bus1.m_last, bus1.m_data});
        rxc1.push_back(cyc);
        accepted1++;
      end
      if (bus2.m_valid && bus2.m_ready) begin
        rx2.push_back({bus2.m_last, bus2.m_data});
        rxc2.push_back(cyc);
      end
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_stream(input string tag, input logic [8:0] q [$], input int qc [$],
                              input int rb, input logic [ADDR_W-1:0] base, input int n,
                              input int len, input int first_cyc);
    logic [8:0] got, exp;
    check({tag, "_count"}, 32'(q.size() - rb), 32'(n));
    for (int i = 0; i < n; i++) begin
      got = (rb + i < q.size()) ? q[rb + i] : 9'h1FF;
      exp = {(i == len - 1), bram_val(ADDR_W'(base + i))};
      check($sformatf("%s_byte%0d", tag, i), {23'b0, got}, {23'b0, exp});
      if (first_cyc >= 0)
        check($sformatf("%s_cyc%0d", tag, i), (rb + i < qc.size()) ? 32'(qc[rb + i]) : 32'hFFFF_FFFF,
              32'(first_cyc + i));
    end
  endtask

  task automatic do_start(input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] l, output int s);
    @(negedge clk);
    base_addr = b;
    length    = l;
    control   = 32'h1;
    s         = cyc;
    @(negedge clk);
    control = 32'h0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (status[0] && k < budget);
    check({tag, "_idle"}, {31'b0, status[0]}, 32'h0);
  endtask

  logic [7:0]        t1_exp [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
  logic [7:0]        t2_exp [4] = '{8'hA4, 8'hA5, 8'h5A, 8'h5B};
  logic [ADDR_W-1:0] t2_adr [4] = '{18'h3FFFE, 18'h3FFFF, 18'h00000, 18'h00001};
  logic [15:0]       rdy_pat    = 16'b1001_0110_1100_1011;

  initial begin
    int s, rb, eb, hs, vb, ib;
    control        = 32'h0;
    control2       = 32'h0;
    base_addr      = '0;
    length         = '0;
    bus1.m_ready   = 1'b0;
    bus2.m_ready   = 1'b0;

    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check("rst_status",  status, 32'h0);
    check("rst_bram_en", {31'b0, bus1.bram_en}, 32'h0);
    check("rst_addr",    32'(bus1.bram_addr), 32'h0);
    check("rst_valid",   {31'b0, bus1.m_valid}, 32'h0);
    check("rst_last",    {31'b0, bus1.m_last}, 32'h0);
    check("rst_data",    32'(bus1.m_data), 32'h0);

    // Basic four-byte readout, exact cycle timing.
    bus1.m_ready = 1'b1;
    rb = rx1.size();
    eb = ena1.size();
    do_start(18'h00010, 18'd4, s);
    check("t1_busy", {31'b0, status[0]}, 32'h1);
    repeat (6) @(negedge clk);
    check("t1_status", status, 32'h0000_0012);
    check("t1_valid_after", {31'b0, bus1.m_valid}, 32'h0);
    check("t1_count", 32'(rx1.size() - rb), 32'd4);
    check("t1_en_count", 32'(ena1.size() - eb), 32'd4);
    check("t1_first_en", (eb < enc1.size()) ? 32'(enc1[eb]) : 32'hFFFF_FFFF, 32'(s + 1));
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t1_byte%0d", i), (rb + i < rx1.size()) ? {23'b0, rx1[rb + i]} : 32'hFFFF_FFFF,
            {23'b0, (i == 3), t1_exp[i]});
      check($sformatf("t1_cyc%0d", i), (rb + i < rxc1.size()) ? 32'(rxc1[rb + i]) : 32'hFFFF_FFFF,
            32'(s + 3 + i));
      check($sformatf("t1_addr%0d", i), (eb + i < ena1.size()) ? 32'(ena1[eb + i]) : 32'hFFFF_FFFF,
            32'h10 + 32'(i));
    end

    // Address wrap at the top of the BRAM.
    rb = rx1.size();
    eb = ena1.size();
    do_start(18'h3FFFE, 18'd4, s);
    wait_idle("t2", 40);
    check("t2_en_count", 32'(ena1.size() - eb), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t2_addr%0d", i), (eb + i < ena1.size()) ? 32'(ena1[eb + i]) : 32'hFFFF_FFFF,
            32'(t2_adr[i]));
      check($sformatf("t2_byte%0d", i), (rb + i < rx1.size()) ? {23'b0, rx1[rb + i]} : 32'hFFFF_FFFF,
            {23'b0, (i == 3), t2_exp[i]});
    end

    // Backpressure with an irregular ready pattern.
    rb = rx1.size();
    @(negedge clk);
    base_addr = 18'h00100;
    length    = 18'd16;
    control   = 32'h1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      control      = 32'h0;
      bus1.m_ready = rdy_pat[k % 16];
      if (k > 2 && !status[0]) break;
    end
    bus1.m_ready = 1'b1;
    check("t3_status", status, 32'h0000_0042);
    check_stream("t3", rx1, rxc1, rb, 18'h00100, 16, 16, -1);
    check("t3_outstanding_le_depth", {31'b0, (max_out1 <= 4)}, 32'h1);

    // Abort after five handshakes of a 32-byte transfer.
    rb = rx1.size();
    do_start(18'h00200, 18'd32, s);
    hs = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus1.m_valid && bus1.m_ready) hs++;
      if (hs == 5) break;
    end
    @(negedge clk);
    bus1.m_ready = 1'b0;
    control      = 32'h2;
    @(negedge clk);
    control = 32'h0;
    check("t4_status", status, 32'h0000_0014);
    check("t4_valid", {31'b0, bus1.m_valid}, 32'h0);
    check("t4_bram_en", {31'b0, bus1.bram_en}, 32'h0);
    repeat (4) @(negedge clk);
    check("t4_valid_later", {31'b0, bus1.m_valid}, 32'h0);
    check_stream("t4", rx1, rxc1, rb, 18'h00200, 5, 32, -1);
    bus1.m_ready = 1'b1;
    rb = rx1.size();
    do_start(18'h00300, 18'd2, s);
    wait_idle("t4b", 40);
    check("t4b_status", status, 32'h0000_000A);
    check_stream("t4b", rx1, rxc1, rb, 18'h00300, 2, 2, -1);

    // Zero-length start, then a start pulse while busy is ignored.
    vb = valid_cnt1;
    ib = issued1;
    do_start(18'h00040, 18'd0, s);
    @(negedge clk);
    check("t5_zero_status", status, 32'h0000_0002);
    @(negedge clk);
    check("t5_zero_no_en", 32'(issued1 - ib), 32'h0);
    check("t5_zero_no_valid", 32'(valid_cnt1 - vb), 32'h0);
    rb = rx1.size();
    do_start(18'h00400, 18'd8, s);
    @(negedge clk);
    control = 32'h1;
    @(negedge clk);
    control = 32'h0;
    wait_idle("t5", 60);
    check("t5_status", status, 32'h0000_0022);
    repeat (10) @(negedge clk);
    check("t5_status_later", status, 32'h0000_0022);
    check_stream("t5", rx1, rxc1, rb, 18'h00400, 8, 8, -1);

    // RD_LAT=2 instance: first byte four cycles after start, then back-to-back.
    bus2.m_ready = 1'b1;
    rb = rx2.size();
    @(negedge clk);
    base_addr = 18'h00010;
    length    = 18'd8;
    control2  = 32'h1;
    s         = cyc;
    @(negedge clk);
    control2 = 32'h0;
    repeat (20) @(negedge clk);
    check("t6_status", status2, 32'h0000_0022);
    check_stream("t6", rx2, rxc2, rb, 18'h00010, 8, 8, s + 4);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1);
  end
endmodule
